// File: rtl/bus_arbiter.sv
`timescale 1ns/1ps
// bus_arbiter: round-robin arbiter that shares a single bus access engine
// between the Pi requester (REQ0) and the DMA requester (REQ1). It also
// handles the nBR / nBG / nBGACK ownership handshake with the external bus.
// Optional macro BUS_ARB_HOLD_EN: keep bus ownership for HOLD_CYCLES idle
// cycles after the last transfer instead of releasing it immediately.
module bus_arbiter #(
  parameter int unsigned HOLD_CYCLES = 64
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic        REQ0_VALID,
  input  logic [29:0] REQ0_CMD,
  input  logic [31:0] REQ0_WDATA,
  output logic        REQ0_ACK,
  input  logic        REQ1_VALID,
  input  logic [29:0] REQ1_CMD,
  input  logic [31:0] REQ1_WDATA,
  output logic        REQ1_ACK,
  output logic        ENG_START,
  output logic [29:0] ENG_CMD,
  output logic [31:0] ENG_WDATA,
  input  logic        ENG_DONE,
  output logic        DONE,
  output logic        DONE_ID,
  input  logic        nBG_SYNC,
  output logic        BR_DRIVE,
  output logic        BGACK_DRIVE,
  output logic        OWNED
);

  typedef enum logic [2:0] {
    IDLE,
    ARB_REQ,
    OWN,
    ISSUE,
    WAIT_DONE,
    RELEASE
  } state_e;

  // A hold window of zero idle cycles has no meaning for this handshake.
  if (HOLD_CYCLES < 1) begin : g_hold_check
    $error("bus_arbiter: HOLD_CYCLES must be at least 1");
  end

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [29:0] cmd_q, cmd_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        done_id_q, done_id_d;
  logic        any_valid;
  logic        winner;

`ifdef BUS_ARB_HOLD_EN
  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  assign any_valid = REQ0_VALID | REQ1_VALID;
  // With both requesting, the one not served last goes next; otherwise the
  // single active requester wins.
  assign winner = (REQ0_VALID && REQ1_VALID) ? ~last_q : ~REQ0_VALID;

  // Next-state logic: ownership handshake, arbitration and engine sequencing.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    cmd_d     = cmd_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
`ifdef BUS_ARB_HOLD_EN
    hold_cnt_d = '0;
`endif
    case (state_q)
      IDLE: begin
        if (any_valid) state_d = ARB_REQ;
      end
      ARB_REQ: begin
        if (!nBG_SYNC) state_d = OWN;
      end
      OWN: begin
        if (any_valid) begin
          state_d = ISSUE;
          owner_d = winner;
          last_d  = winner;
          cmd_d   = winner ? REQ1_CMD : REQ0_CMD;
          wdata_d = winner ? REQ1_WDATA : REQ0_WDATA;
        end else begin
`ifdef BUS_ARB_HOLD_EN
          if (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            state_d = RELEASE;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
`else
          state_d = RELEASE;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (ENG_DONE) begin
          state_d   = OWN;
          done_d    = 1'b1;
          done_id_d = owner_q;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight cycle.
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      cmd_q      <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
`ifdef BUS_ARB_HOLD_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      cmd_q      <= cmd_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
`ifdef BUS_ARB_HOLD_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  // Outputs decode the registered state, so they are glitch-free and all
  // drop to zero as soon as reset is applied.
  assign BR_DRIVE    = (state_q == ARB_REQ);
  assign BGACK_DRIVE = state_q inside {OWN, ISSUE, WAIT_DONE, RELEASE};
  assign OWNED       = state_q inside {OWN, ISSUE, WAIT_DONE};
  assign ENG_START   = (state_q == ISSUE);
  assign REQ0_ACK    = ENG_START & ~owner_q;
  assign REQ1_ACK    = ENG_START & owner_q;
  assign ENG_CMD     = cmd_q;
  assign ENG_WDATA   = wdata_q;
  assign DONE        = done_q;
  assign DONE_ID     = done_id_q;

endmodule
